// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Stall/flush sequencer for the 5-stage core_lapido pipeline. It arbitrates
//   the data-memory wait, a taken branch resolved in EX and a load-use
//   dependency into one set of pipeline-register enables and flushes. It also
//   owns the halt/resume state and a memory-wait watchdog.
//
//   Optional build macro: PIPE_PERF_COUNTERS_EN adds saturating stall_cycles
//   and flush_count outputs.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ID_EX_is_load, ID_EX_rt    load currently in EX and its destination reg
//   IF_ID_rs/rt, IF_ID_uses_*  ID-stage sources and whether they are read
//   EX_branch_taken            taken branch/jump resolved in EX
//   EX_MEM_mem_req, mem_ready  MEM-stage access and its completion
//   halt_req, resume           halt level request, one-cycle resume pulse
//   pc_write .. MEM_WB_flush   combinational pipeline enables/flushes
//   mem_timeout_err            sticky watchdog error (registered)
//   ctrl_state                 RUN=0, MEM_WAIT=1, HALTED=2, ERROR=3
//   stall_cycles, flush_count  perf counters (PIPE_PERF_COUNTERS_EN only)
module pipeline_stall_controller #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ID_EX_is_load,
  input  logic [REG_ADDR_W-1:0] ID_EX_rt,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs,
  input  logic [REG_ADDR_W-1:0] IF_ID_rt,
  input  logic                  IF_ID_uses_rs,
  input  logic                  IF_ID_uses_rt,
  input  logic                  EX_branch_taken,
  input  logic                  EX_MEM_mem_req,
  input  logic                  mem_ready,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  pc_write,
  output logic                  IF_ID_write,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_write,
  output logic                  ID_EX_flush,
  output logic                  EX_MEM_write,
  output logic                  MEM_WB_flush,
  output logic                  mem_timeout_err,
`ifdef PIPE_PERF_COUNTERS_EN
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count,
`endif
  output logic [1:0]            ctrl_state
);

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2,
    ERROR    = 2'd3
  } state_t;

  // Output bundle, order: pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f
  localparam logic [6:0] OUT_RUN    = 7'b1101010;
  localparam logic [6:0] OUT_FREEZE = 7'b0000001;
  localparam logic [6:0] OUT_BRANCH = 7'b1111110;
  localparam logic [6:0] OUT_BUBBLE = 7'b0001110;

  state_t          state;
  logic [WD_W-1:0] wd_cnt;
  logic            load_use;
  logic            mem_busy;
  logic [6:0]      outs;
  logic [6:0]      flow_outs;

  assign load_use = ID_EX_is_load && (ID_EX_rt != '0) &&
                    ((IF_ID_uses_rs && (ID_EX_rt == IF_ID_rs)) ||
                     (IF_ID_uses_rt && (ID_EX_rt == IF_ID_rt)));
  assign mem_busy = EX_MEM_mem_req && !mem_ready;

  // Branch beats load-use: the dependent instruction is being squashed anyway.
  always_comb begin
    flow_outs = OUT_RUN;
    if (EX_branch_taken)
      flow_outs = OUT_BRANCH;
    else if (load_use)
      flow_outs = OUT_BUBBLE;
  end

  always_comb begin
    outs = OUT_RUN;
    case (state)
      RUN:      outs = mem_busy ? OUT_FREEZE : flow_outs;
      // Release cycle re-evaluates hazards that were masked while frozen.
      MEM_WAIT: outs = mem_ready ? flow_outs : OUT_FREEZE;
      HALTED:   outs = OUT_BUBBLE;
      ERROR:    outs = OUT_FREEZE;
      default:  outs = OUT_FREEZE;
    endcase
  end

  assign {pc_write, IF_ID_write, IF_ID_flush, ID_EX_write,
          ID_EX_flush, EX_MEM_write, MEM_WB_flush} = outs;
  assign ctrl_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RUN;
      wd_cnt          <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            state  <= MEM_WAIT;
            wd_cnt <= WD_W'(1);
          end else if (halt_req && !EX_branch_taken && !load_use) begin
            state <= HALTED;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state  <= RUN;
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
            // Counter about to reach MEM_TIMEOUT: trip the watchdog.
            if (wd_cnt >= WD_W'(MEM_TIMEOUT - 1)) begin
              state           <= ERROR;
              mem_timeout_err <= 1'b1;
            end
          end
        end
        HALTED: begin
          if (resume) state <= RUN;
        end
        ERROR: begin
          mem_timeout_err <= 1'b1;
        end
        default: state <= ERROR;
      endcase
    end
  end

`ifdef PIPE_PERF_COUNTERS_EN
  logic stall_evt;
  assign stall_evt = !pc_write && ((state == RUN) || (state == MEM_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_evt && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (IF_ID_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
module tb_pipeline_stall_controller;

  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          is_load, uses_rs, uses_rt, br, mem_req, mem_ready, halt_req, resume;
  logic [RW-1:0] ex_rt, id_rs, id_rt;
  logic          pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
  logic          ex_mem_write, mem_wb_flush, err;
  logic [1:0]    st;
`ifdef PIPE_PERF_COUNTERS_EN
  logic [31:0]   stall_cycles, flush_count, snap;
`endif

  int checks = 0;
  int errors = 0;

  // pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_f
  localparam logic [6:0] E_RUN    = 7'b1101010;
  localparam logic [6:0] E_FREEZE = 7'b0000001;
  localparam logic [6:0] E_BRANCH = 7'b1111110;
  localparam logic [6:0] E_BUBBLE = 7'b0001110;

  pipeline_stall_controller #(.REG_ADDR_W(RW), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_is_load(is_load), .ID_EX_rt(ex_rt),
    .IF_ID_rs(id_rs), .IF_ID_rt(id_rt),
    .IF_ID_uses_rs(uses_rs), .IF_ID_uses_rt(uses_rt),
    .EX_branch_taken(br), .EX_MEM_mem_req(mem_req), .mem_ready(mem_ready),
    .halt_req(halt_req), .resume(resume),
    .pc_write(pc_write), .IF_ID_write(if_id_write), .IF_ID_flush(if_id_flush),
    .ID_EX_write(id_ex_write), .ID_EX_flush(id_ex_flush),
    .EX_MEM_write(ex_mem_write), .MEM_WB_flush(mem_wb_flush),
    .mem_timeout_err(err),
`ifdef PIPE_PERF_COUNTERS_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .ctrl_state(st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    is_load = 0; ex_rt = 0; id_rs = 0; id_rt = 0; uses_rs = 0; uses_rt = 0;
    br = 0; mem_req = 0; mem_ready = 0; halt_req = 0; resume = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    chk("rst_state", 32'(st), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_outs", 32'(outs()), 32'(E_RUN));
`ifdef PIPE_PERF_COUNTERS_EN
    chk("rst_stall_cnt", stall_cycles, 0);
`endif
    rst_n = 1;
    tick();

    // load-use on rs: one bubble, then clean once the load has moved on
    is_load = 1; ex_rt = 8; id_rs = 8; uses_rs = 1; #1;
    chk("lu_rs", 32'(outs()), 32'(E_BUBBLE));
    tick();
    is_load = 0; #1;
    chk("lu_after", 32'(outs()), 32'(E_RUN));
    chk("lu_state", 32'(st), 0);

    // load-use on rt
    idle(); is_load = 1; ex_rt = 5; id_rt = 5; uses_rt = 1; id_rs = 3; uses_rs = 1; #1;
    chk("lu_rt", 32'(outs()), 32'(E_BUBBLE));

    // register-zero guard and unused-source guard
    idle(); is_load = 1; ex_rt = 0; id_rs = 0; uses_rs = 1; #1;
    chk("r0_guard", 32'(outs()), 32'(E_RUN));
    idle(); is_load = 1; ex_rt = 8; id_rs = 8; uses_rs = 0; #1;
    chk("unused_rs", 32'(outs()), 32'(E_RUN));

    // branch beats load-use
    idle(); is_load = 1; ex_rt = 8; id_rs = 8; uses_rs = 1; br = 1; #1;
    chk("br_vs_lu", 32'(outs()), 32'(E_BRANCH));
    tick();
    chk("br_state", 32'(st), 0);

    // mem wait 3 cycles; first cycle also has a branch that must be masked
    idle(); mem_req = 1; br = 1; #1;
    chk("mw_c1_outs", 32'(outs()), 32'(E_FREEZE));
    tick(); br = 0; #1;
    chk("mw_c2_state", 32'(st), 1);
    chk("mw_c2_outs", 32'(outs()), 32'(E_FREEZE));
    tick();
    chk("mw_c3_state", 32'(st), 1);
    chk("mw_c3_outs", 32'(outs()), 32'(E_FREEZE));
    tick();
    mem_ready = 1; #1;
    chk("mw_rel_state", 32'(st), 1);
    chk("mw_rel_outs", 32'(outs()), 32'(E_RUN));
    tick();
    chk("mw_done_state", 32'(st), 0);

    // release cycle re-evaluates load-use
    idle(); mem_req = 1; tick();
    mem_ready = 1; is_load = 1; ex_rt = 9; id_rt = 9; uses_rt = 1; #1;
    chk("mw_rel_lu", 32'(outs()), 32'(E_BUBBLE));
    tick();
    chk("mw_rel_lu_state", 32'(st), 0);

    // watchdog: 16 consecutive wait cycles trip ERROR
    idle(); mem_req = 1;
    repeat (15) tick();
    chk("wd_15_state", 32'(st), 1);
    chk("wd_15_err", 32'(err), 0);
    tick();
    chk("wd_16_state", 32'(st), 3);
    chk("wd_16_err", 32'(err), 1);
    chk("wd_outs", 32'(outs()), 32'(E_FREEZE));
    mem_ready = 1; mem_req = 0; halt_req = 1; resume = 1;
    repeat (3) tick();
    chk("err_sticky_state", 32'(st), 3);
    chk("err_sticky_err", 32'(err), 1);
    #2 rst_n = 0; #1;
    chk("async_rst_state", 32'(st), 0);
    chk("async_rst_err", 32'(err), 0);
    #1 rst_n = 1;
    idle();
    tick();

    // halt: halt_req doesn't change this cycle's outputs, only next state
    halt_req = 1; #1;
    chk("halt_req_outs", 32'(outs()), 32'(E_RUN));
    tick();
    chk("halted_state", 32'(st), 2);
    chk("halted_outs", 32'(outs()), 32'(E_BUBBLE));
`ifdef PIPE_PERF_COUNTERS_EN
    snap = stall_cycles;
`endif
    repeat (3) tick();
    chk("halted_hold", 32'(st), 2);
`ifdef PIPE_PERF_COUNTERS_EN
    chk("halted_no_stall_cnt", stall_cycles, snap);
`endif
    // resume together with halt_req: one RUN cycle then re-halt
    resume = 1; tick(); resume = 0; #1;
    chk("resume_run", 32'(st), 0);
    tick();
    chk("rehalt", 32'(st), 2);
    halt_req = 0; resume = 1; tick(); resume = 0;
    chk("resume_final", 32'(st), 0);

    // halt is not taken while a load-use is pending
    halt_req = 1; is_load = 1; ex_rt = 4; id_rs = 4; uses_rs = 1; tick();
    chk("halt_vs_lu", 32'(st), 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
